math_pipelined_sequencer: RTL and testbench
===========================================

Name: math_pipelined_sequencer

Overview:
- Control stage that wraps `math_pipelined`: it drives that unit's inputs and consumes its outputs.
- Takes one add or subtract request per valid/ready transaction and holds the accumulator that feeds back into I1.
- Pulses ce to load the B operand, then clocks the carry chain through every chunk.
- Waits for the flag trees to settle, then presents result and flags on a valid/ready output. Sits between the request source and the downstream consumer.

Parameters:
- WIDTH, 4, operand/result width; passed to `math_pipelined`.
- LATENCY, 4, latency parameter passed to `math_pipelined`; sets CHUNK_COUNT (see below).
- FLAG_WAIT, LATENCY+1, cycles to wait after the accumulator is final before sampling the gate/cmp outputs; must be ≥1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  1  0 = add (a+b), 1 = subtract (a-b).
- in_a  in  WIDTH  first operand.
- in_b  in  WIDTH  second operand.
- in_c  in  WIDTH  compare operand.
- alu_ce  out  1  to ALU ce.
- alu_i1  out  WIDTH  to ALU I1 (accumulator).
- alu_i2  out  WIDTH  to ALU I2.
- alu_i3  out  WIDTH  to ALU I3.
- alu_sum  in  WIDTH  from ALU sum.
- alu_sub  in  WIDTH  from ALU sub.
- alu_and, alu_or, alu_xor, alu_eq  in  1 each  from ALU.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  WIDTH  final a±b, modulo 2^WIDTH.
- out_and, out_or, out_xor, out_eq  out  1 each  reduction AND/OR/XOR of out_result; out_eq = (out_result == c).

Behaviour:
- Derived: ALU_W = ceil(WIDTH/LATENCY); CHUNK_COUNT = ceil(WIDTH/ALU_W). Example: WIDTH=8, LATENCY=3 → ALU_W=3, CHUNK_COUNT=3.
- Reset (rst_n low, async): state=IDLE, all registers 0.
  - Outputs: in_ready=1 (it is IDLE-decoded), out_valid=0, alu_ce=0, alu_i1/i2/i3=0, out_* = 0.
- FSM states: IDLE, LOAD, PROP, SETTLE, DONE.
- IDLE:
  - in_ready=1.
  - On accept: acc←in_a, b_reg←in_b, c_reg←in_c, op_reg←in_op; → LOAD.
- LOAD (1 cycle):
  - alu_ce=1, alu_i2=b_reg.
  - cnt←CHUNK_COUNT-1; → PROP.
- PROP (exactly CHUNK_COUNT cycles):
  - alu_ce=0, alu_i2=0.
  - Each cycle acc←(op_reg ? alu_sub : alu_sum); cnt decrements.
  - First PROP cycle adds/subtracts b; later cycles ripple one chunk carry/borrow each.
  - On cnt==0 (after the final write) → SETTLE with cnt←FLAG_WAIT-1.
- SETTLE (FLAG_WAIT cycles):
  - acc frozen.
  - On cnt==0: capture out_result←acc and out_and/or/xor/eq←alu_*; → DONE.
- DONE:
  - out_valid=1; outputs stable until out_valid && out_ready, then → IDLE.
  - in_ready=0 in every non-IDLE state, so there is no overlap. Earliest new accept is the cycle after the out handshake.
- alu_i1=acc and alu_i3=c_reg at all times; alu_ce is high only in LOAD.
- Latency: accept edge to out_valid = 1 + CHUNK_COUNT + FLAG_WAIT + 1 cycles.
- Arithmetic: wrap modulo 2^WIDTH; no carry/borrow output. Sub of a<b gives the two's-complement wrap.
- out_ready high while not in DONE: ignored.
- in_valid held during busy: not accepted; the request source keeps it held.
- CHUNK_COUNT=1: PROP lasts 1 cycle.
- Reset asserted mid-operation: immediately aborts to IDLE. alu_ce drops asynchronously; no stale out_valid.

Test Plan:
- WIDTH=8, LATENCY=3, FLAG_WAIT=4, add a=0x7F b=0x81 c=0x00 → out_result=0x00, out_eq=1, out_and=0, out_or=0, out_xor=0; out_valid exactly 9 cycles after accept edge.
- Same config, sub a=0x10 b=0x11 c=0xFF → out_result=0xFF, out_eq=1, out_and=1, out_or=1, out_xor=0 (borrow rippled through all 3 chunks).
- Add a=0x0F b=0x01 c=0x10 → 0x10, eq=1, xor=1. Hold out_ready=0 for 5 cycles → out_valid and all outputs stay stable; in_ready=0 throughout; accepted on the first out_ready=1.
- Back-to-back: in_valid held high with two requests, out_ready tied 1 → second accept is 1 cycle after the first out handshake; second result correct and independent of the first acc.
- Reset pulse during PROP of add 0xFF+0x01 → alu_ce=0, out_valid=0, in_ready=1 immediately. Next request 0x02+0x03 → 0x05.
- WIDTH=4, LATENCY=4 (CHUNK_COUNT=4): sweep all 256 a,b pairs for add and sub against a model; out_eq checked with c=expected and c=expected^1.

Source files
------------

// File: rtl/math_pipelined_sequencer.sv
// Control stage for math_pipelined: accepts one add/sub request, loads the
// B operand with a single ce pulse, lets the chunked carry chain ripple for
// CHUNK_COUNT cycles, waits for the flag trees, then presents the result.
module math_pipelined_sequencer #(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 4,
  parameter int FLAG_WAIT = LATENCY + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             alu_ce,
  output logic [WIDTH-1:0] alu_i1,
  output logic [WIDTH-1:0] alu_i2,
  output logic [WIDTH-1:0] alu_i3,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic [WIDTH-1:0] alu_sub,
  input  logic             alu_and,
  input  logic             alu_or,
  input  logic             alu_xor,
  input  logic             alu_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             out_eq
);

  localparam int ALU_W       = (WIDTH + LATENCY - 1) / LATENCY;
  localparam int CHUNK_COUNT = (WIDTH + ALU_W - 1) / ALU_W;
  localparam int CNT_MAX     = (CHUNK_COUNT > FLAG_WAIT) ? CHUNK_COUNT : FLAG_WAIT;
  localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PROP,
    SETTLE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;
  logic             op_reg;
  logic [CNT_W-1:0] cnt;

  // Accumulator feeds back into I1; compare operand held on I3.
  assign alu_i1 = acc;
  assign alu_i3 = c_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded handshake/ALU controls.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    alu_ce     = 1'b0;
    alu_i2     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        alu_ce     = 1'b1;
        alu_i2     = b_reg;
        state_next = PROP;
      end
      PROP: begin
        if (cnt == '0) state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, accumulator update, cycle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      op_reg     <= 1'b0;
      cnt        <= '0;
      out_result <= '0;
      out_and    <= 1'b0;
      out_or     <= 1'b0;
      out_xor    <= 1'b0;
      out_eq     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= in_a;
            b_reg  <= in_b;
            c_reg  <= in_c;
            op_reg <= in_op;
          end
        end
        LOAD: begin
          cnt <= CNT_W'(CHUNK_COUNT - 1);
        end
        PROP: begin
          // First cycle applies B; later cycles ripple one chunk carry each.
          acc <= op_reg ? alu_sub : alu_sum;
          if (cnt == '0) begin
            cnt <= CNT_W'(FLAG_WAIT - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            out_result <= acc;
            out_and    <= alu_and;
            out_or     <= alu_or;
            out_xor    <= alu_xor;
            out_eq     <= alu_eq;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_math_pipelined_sequencer.sv
// Bench for math_pipelined_sequencer: two configurations (8/3/4 and 4/4/5),
// each wrapped around a behavioural chunked-carry ALU with delayed flags.
module tb_math_pipelined_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One ALU step: chunk-local add/sub with carries/borrows held at chunk bases.
  // Returns {carry mask for next cycle, result}.
  function automatic logic [15:0] chunk_step(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] cin, input int unsigned w,
                                             input int unsigned cw, input bit sub);
    logic [7:0] r;
    logic [7:0] co;
    logic       c;
    r  = '0;
    co = '0;
    c  = 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      if (i % cw == 0) c = cin[i];
      r[i] = a[i] ^ b[i] ^ c;
      if (sub) c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
      else     c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      if (((i % cw == cw - 1) || (i == w - 1)) && (i + 1 < w)) co[i+1] = c;
    end
    return {co, r};
  endfunction

  // ---------------- configuration A: WIDTH=8 LATENCY=3 FLAG_WAIT=4 ----------
  localparam int FD_A = 3;
  logic       a_in_valid, a_in_ready, a_in_op;
  logic [7:0] a_in_a, a_in_b, a_in_c;
  logic       a_alu_ce;
  logic [7:0] a_alu_i1, a_alu_i2, a_alu_i3, a_alu_sum, a_alu_sub;
  logic       a_alu_and, a_alu_or, a_alu_xor, a_alu_eq;
  logic       a_out_valid, a_out_ready;
  logic [7:0] a_out_result;
  logic       a_out_and, a_out_or, a_out_xor, a_out_eq;

  logic [7:0]  ma_opb, ma_cm, ma_bm;
  logic [15:0] ma_add, ma_sub;
  logic [3:0]  ma_fp [0:7];

  always_comb begin
    ma_add = chunk_step(a_alu_i1, ma_opb, ma_cm, 8, 3, 1'b0);
    ma_sub = chunk_step(a_alu_i1, ma_opb, ma_bm, 8, 3, 1'b1);
  end
  assign a_alu_sum = ma_add[7:0];
  assign a_alu_sub = ma_sub[7:0];
  assign {a_alu_and, a_alu_or, a_alu_xor, a_alu_eq} = ma_fp[FD_A-1];

  always @(posedge clk) begin
    ma_opb   <= a_alu_i2;
    ma_cm    <= a_alu_ce ? 8'h00 : ma_add[15:8];
    ma_bm    <= a_alu_ce ? 8'h00 : ma_sub[15:8];
    ma_fp[0] <= {&a_alu_i1, |a_alu_i1, ^a_alu_i1, a_alu_i1 == a_alu_i3};
    for (int k = 1; k < 8; k++) ma_fp[k] <= ma_fp[k-1];
  end

  math_pipelined_sequencer #(.WIDTH(8), .LATENCY(3), .FLAG_WAIT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_a(a_in_a), .in_b(a_in_b), .in_c(a_in_c),
    .alu_ce(a_alu_ce), .alu_i1(a_alu_i1), .alu_i2(a_alu_i2), .alu_i3(a_alu_i3),
    .alu_sum(a_alu_sum), .alu_sub(a_alu_sub),
    .alu_and(a_alu_and), .alu_or(a_alu_or), .alu_xor(a_alu_xor), .alu_eq(a_alu_eq),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
    .out_and(a_out_and), .out_or(a_out_or), .out_xor(a_out_xor), .out_eq(a_out_eq)
  );

  // ---------------- configuration B: WIDTH=4 LATENCY=4 (FLAG_WAIT=5) --------
  localparam int FD_B = 4;
  logic       b_in_valid, b_in_ready, b_in_op;
  logic [3:0] b_in_a, b_in_b, b_in_c;
  logic       b_alu_ce;
  logic [3:0] b_alu_i1, b_alu_i2, b_alu_i3, b_alu_sum, b_alu_sub;
  logic       b_alu_and, b_alu_or, b_alu_xor, b_alu_eq;
  logic       b_out_valid, b_out_ready;
  logic [3:0] b_out_result;
  logic       b_out_and, b_out_or, b_out_xor, b_out_eq;

  logic [3:0]  mb_opb;
  logic [7:0]  mb_cm, mb_bm;
  logic [15:0] mb_add, mb_sub;
  logic [3:0]  mb_fp [0:7];

  always_comb begin
    mb_add = chunk_step({4'h0, b_alu_i1}, {4'h0, mb_opb}, mb_cm, 4, 1, 1'b0);
    mb_sub = chunk_step({4'h0, b_alu_i1}, {4'h0, mb_opb}, mb_bm, 4, 1, 1'b1);
  end
  assign b_alu_sum = mb_add[3:0];
  assign b_alu_sub = mb_sub[3:0];
  assign {b_alu_and, b_alu_or, b_alu_xor, b_alu_eq} = mb_fp[FD_B-1];

  always @(posedge clk) begin
    mb_opb   <= b_alu_i2;
    mb_cm    <= b_alu_ce ? 8'h00 : mb_add[15:8];
    mb_bm    <= b_alu_ce ? 8'h00 : mb_sub[15:8];
    mb_fp[0] <= {&b_alu_i1, |b_alu_i1, ^b_alu_i1, b_alu_i1 == b_alu_i3};
    for (int k = 1; k < 8; k++) mb_fp[k] <= mb_fp[k-1];
  end

  math_pipelined_sequencer #(.WIDTH(4), .LATENCY(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_a(b_in_a), .in_b(b_in_b), .in_c(b_in_c),
    .alu_ce(b_alu_ce), .alu_i1(b_alu_i1), .alu_i2(b_alu_i2), .alu_i3(b_alu_i3),
    .alu_sum(b_alu_sum), .alu_sub(b_alu_sub),
    .alu_and(b_alu_and), .alu_or(b_alu_or), .alu_xor(b_alu_xor), .alu_eq(b_alu_eq),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_and(b_out_and), .out_or(b_out_or), .out_xor(b_out_xor), .out_eq(b_out_eq)
  );

  // ---------------- helpers ----------------
  task automatic a_wait_accept();
    bit done = 1'b0;
    int n    = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (a_in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      n++;
    end
    check("a_accept_seen", done, 1);
  endtask

  task automatic b_wait_accept();
    bit done = 1'b0;
    int n    = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (b_in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      n++;
    end
    check("b_accept_seen", done, 1);
  endtask

  // Cycle index counted with the accept cycle as 0.
  task automatic a_wait_valid(input int start, output int lat);
    bit seen = 1'b0;
    lat = start;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (a_out_valid) seen = 1'b1;
    end
    check("a_valid_seen", seen, 1);
  endtask

  task automatic b_wait_valid(input int start, output int lat);
    bit seen = 1'b0;
    lat = start;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (b_out_valid) seen = 1'b1;
    end
    check("b_valid_seen", seen, 1);
  endtask

  // Present a request, check the LOAD cycle and the first PROP cycle controls.
  task automatic a_request(input logic op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input bit hold_valid);
    a_in_op    = op;
    a_in_a     = a;
    a_in_b     = b;
    a_in_c     = c;
    a_in_valid = 1'b1;
    a_wait_accept();
    #1;
    if (!hold_valid) a_in_valid = 1'b0;
    check("a_load_ce", a_alu_ce, 1);
    check("a_load_i2", a_alu_i2, b);
    check("a_load_i1", a_alu_i1, a);
    check("a_load_i3", a_alu_i3, c);
    check("a_load_in_ready", a_in_ready, 0);
    @(posedge clk);
    #1;
    check("a_prop_ce", a_alu_ce, 0);
    check("a_prop_i2", a_alu_i2, 0);
  endtask

  task automatic a_expect(input logic [7:0] r, input logic e, input logic an,
                          input logic o, input logic x);
    check("a_result", a_out_result, r);
    check("a_eq", a_out_eq, e);
    check("a_and", a_out_and, an);
    check("a_or", a_out_or, o);
    check("a_xor", a_out_xor, x);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         lat;
    logic [7:0] hold_r;
    logic [3:0] hold_f;
    logic [3:0] exp4;
    logic [3:0] c4;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_op     = 1'b0;
    a_in_a      = '0;
    a_in_b      = '0;
    a_in_c      = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_op     = 1'b0;
    b_in_a      = '0;
    b_in_b      = '0;
    b_in_c      = '0;
    b_out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_alu_ce", a_alu_ce, 0);
    check("rst_alu_i1", a_alu_i1, 0);
    check("rst_alu_i2", a_alu_i2, 0);
    check("rst_alu_i3", a_alu_i3, 0);
    check("rst_out_result", a_out_result, 0);
    check("rst_out_flags", {a_out_and, a_out_or, a_out_xor, a_out_eq}, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x7F + 0x81 wraps to 0x00 with a carry rippled through all chunks.
    a_request(1'b0, 8'h7F, 8'h81, 8'h00, 1'b0);
    a_wait_valid(2, lat);
    check("a_latency", lat, 9);
    a_expect(8'h00, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("a_hs_out_valid", a_out_valid, 0);
    check("a_hs_in_ready", a_in_ready, 1);

    // 0x10 - 0x11 borrows through every chunk.
    a_request(1'b1, 8'h10, 8'h11, 8'hFF, 1'b0);
    a_wait_valid(2, lat);
    check("a_latency_sub", lat, 9);
    a_expect(8'hFF, 1, 1, 1, 0);
    @(posedge clk);
    #1;

    // Backpressure: outputs hold while out_ready is low; a waiting request is not taken.
    a_out_ready = 1'b0;
    a_request(1'b0, 8'h0F, 8'h01, 8'h10, 1'b0);
    a_wait_valid(2, lat);
    a_expect(8'h10, 1, 0, 1, 1);
    hold_r     = a_out_result;
    hold_f     = {a_out_and, a_out_or, a_out_xor, a_out_eq};
    a_in_valid = 1'b1;
    a_in_a     = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", a_out_valid, 1);
      check("hold_result", a_out_result, 8'h10);
      check("hold_flags", {a_out_and, a_out_or, a_out_xor, a_out_eq}, {hold_f});
      check("hold_result_stable", a_out_result, hold_r);
      check("hold_in_ready", a_in_ready, 0);
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", a_out_valid, 0);
    check("hold_release_ready", a_in_ready, 1);

    // Back-to-back with in_valid held high.
    a_request(1'b0, 8'h20, 8'h05, 8'h25, 1'b1);
    a_in_op = 1'b1;
    a_in_a  = 8'h03;
    a_in_b  = 8'h05;
    a_in_c  = 8'h00;
    a_wait_valid(2, lat);
    a_expect(8'h25, 1, 0, 1, 1);
    @(posedge clk);
    #1;
    check("b2b_hs_valid", a_out_valid, 0);
    check("b2b_hs_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    check("b2b_second_ce", a_alu_ce, 1);
    check("b2b_second_i1", a_alu_i1, 8'h03);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    a_wait_valid(2, lat);
    check("b2b_latency", lat, 9);
    a_expect(8'hFE, 0, 0, 1, 1);
    @(posedge clk);
    #1;

    // Asynchronous reset during PROP.
    a_request(1'b0, 8'hFF, 8'h01, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_alu_ce", a_alu_ce, 0);
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_in_ready", a_in_ready, 1);
    check("midrst_acc", a_alu_i1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_request(1'b0, 8'h02, 8'h03, 8'h05, 1'b0);
    a_wait_valid(2, lat);
    check("postrst_latency", lat, 9);
    a_expect(8'h05, 1, 0, 1, 0);

    // Configuration B: exhaustive add/sub with matching and non-matching compare.
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int t = 0; t < 2; t++) begin
            exp4       = (op == 1) ? 4'(a - b) : 4'(a + b);
            c4         = (t == 1) ? (exp4 ^ 4'h1) : exp4;
            b_in_op    = op[0];
            b_in_a     = 4'(a);
            b_in_b     = 4'(b);
            b_in_c     = c4;
            b_in_valid = 1'b1;
            b_wait_accept();
            #1;
            b_in_valid = 1'b0;
            b_wait_valid(1, lat);
            check("b_latency", lat, 11);
            check("b_result", b_out_result, exp4);
            check("b_eq", b_out_eq, (t == 0));
            check("b_and", b_out_and, &exp4);
            check("b_or", b_out_or, |exp4);
            check("b_xor", b_out_xor, ^exp4);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
